// File: rtl/vic_pkg.sv
// rtl/vic_pkg.sv - shared constants, FSM states and PRIO nibble helpers for the vectored interrupt controller
// Contents:
//   ADDR_*              register map addresses on the cfg port
//   vic_state_e         request FSM states (IDLE, REQ)
//   prio_nibble_insert  place a priority into nibble slot of a PRIO register word
//   prio_nibble_extract fetch the nibble of a PRIO register word for one channel
package vic_pkg;

  localparam logic [3:0] ADDR_CTRL       = 4'd0;
  localparam logic [3:0] ADDR_MASK       = 4'd1;
  localparam logic [3:0] ADDR_EDGE       = 4'd2;
  localparam logic [3:0] ADDR_PENDING    = 4'd3;
  localparam logic [3:0] ADDR_IN_SERVICE = 4'd4;
  localparam logic [3:0] ADDR_LAST_ID    = 4'd5;
  localparam logic [3:0] ADDR_PRIO_BASE  = 4'd8;

  // Eight channels share one PRIO register, one nibble each.
  localparam int unsigned PRIO_PER_REG = 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } vic_state_e;

  function automatic logic [31:0] prio_nibble_insert(input logic [31:0] word,
                                                     input logic [2:0]  slot,
                                                     input logic [3:0]  prio);
    logic [31:0] r;
    r = word;
    r[{slot, 2'b00} +: 4] = prio;
    return r;
  endfunction

  function automatic logic [3:0] prio_nibble_extract(input logic [31:0] word,
                                                     input logic [2:0]  slot);
    return word[{slot, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/irq_prio_select.sv
// rtl/irq_prio_select.sv - combinational highest-priority winner selection, lowest index wins ties
// Ports:
//   eligible_i  per-channel eligibility (already qualified by enable, mask, pending, prio > 0)
//   prio_i      per-channel priority
//   valid_o     some channel is eligible
//   id_o        index of the winning channel
//   prio_o      priority of the winning channel
module irq_prio_select #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned PRIO_W  = 2
) (
  input  logic [NUM_IRQ-1:0]             eligible_i,
  input  logic [NUM_IRQ-1:0][PRIO_W-1:0] prio_i,
  output logic                           valid_o,
  output logic [4:0]                     id_o,
  output logic [PRIO_W-1:0]              prio_o
);

  logic              found;
  logic [4:0]        best_id;
  logic [PRIO_W-1:0] best_prio;

  // Ascending scan with strict '>' keeps the lowest index among equal priorities.
  always_comb begin
    found     = 1'b0;
    best_id   = 5'd0;
    best_prio = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible_i[i] && (!found || (prio_i[i] > best_prio))) begin
        found     = 1'b1;
        best_id   = 5'(i);
        best_prio = prio_i[i];
      end
    end
  end

  assign valid_o = found;
  assign id_o    = best_id;
  assign prio_o  = best_prio;

endmodule

// File: rtl/vectored_interrupt_controller.sv
// rtl/vectored_interrupt_controller.sv - priority-nesting vectored interrupt controller with register port
// Ports:
//   clock, reset          core clock, synchronous active-high reset
//   irq_in                raw source lines
//   interrupt             request to the hazard unit (held until int_ack)
//   int_vec_addr, int_id  vector and channel of the held request
//   int_ack, int_return   request taken / return-from-interrupt retired (one-cycle pulses)
//   cfg_wen, cfg_addr, cfg_wdata, cfg_rdata   register port, read data registered
module vectored_interrupt_controller
  import vic_pkg::*;
#(
  parameter int unsigned       NUM_IRQ         = 8,
  parameter int unsigned       PRIO_W          = 2,
  parameter int unsigned       ADDR_W          = 14,
  parameter logic [ADDR_W-1:0] VEC_BASE        = ADDR_W'('h0010),
  parameter int unsigned       VEC_STRIDE_LOG2 = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               interrupt,
  output logic [ADDR_W-1:0]  int_vec_addr,
  output logic [4:0]         int_id,
  input  logic               int_ack,
  input  logic               int_return,
  input  logic               cfg_wen,
  input  logic [3:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata
);

  localparam int unsigned NUM_LEVELS = 1 << PRIO_W;

  // Configuration registers
  logic                           ctrl_en_q, ctrl_en_d;
  logic [NUM_IRQ-1:0]             mask_q, mask_d;
  logic [NUM_IRQ-1:0]             edge_q, edge_d;
  logic [NUM_IRQ-1:0][PRIO_W-1:0] prio_q, prio_d;

  // Source tracking and service state
  logic [NUM_IRQ-1:0]    irq_prev_q;
  logic [NUM_IRQ-1:0]    pend_q, pend_d;
  logic [NUM_LEVELS-1:0] in_service_q, in_service_d;
  logic [4:0]            last_id_q, last_id_d;

  // FSM and its registered outputs
  vic_state_e        state_q;
  logic              interrupt_q;
  logic [4:0]        int_id_q;
  logic [ADDR_W-1:0] int_vec_q;
  logic [PRIO_W-1:0] req_prio_q;

  logic [31:0] cfg_rdata_q, cfg_rdata_d;

  logic [NUM_IRQ-1:0] edge_rise;
  logic [NUM_IRQ-1:0] eff_pend;
  logic [NUM_IRQ-1:0] prio_nz;
  logic [NUM_IRQ-1:0] eligible;
  logic               sel_valid;
  logic [4:0]         sel_id;
  logic [PRIO_W-1:0]  sel_prio;
  logic [ADDR_W-1:0]  sel_vec;
  logic [31:0]        vec_off;
  logic [PRIO_W-1:0]  cur_level;
  logic               ack_fire;
  logic               ret_fire;
  logic               w1c_pend;

  assign edge_rise = irq_in & ~irq_prev_q;

  // Edge channels use the stored bit; level channels follow the line directly.
  assign eff_pend = (edge_q & pend_q) | (~edge_q & irq_in);

  always_comb begin
    prio_nz = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      prio_nz[i] = |prio_q[i];
    end
  end

  assign eligible = {NUM_IRQ{ctrl_en_q}} & mask_q & eff_pend & prio_nz;

  irq_prio_select #(
    .NUM_IRQ(NUM_IRQ),
    .PRIO_W (PRIO_W)
  ) u_select (
    .eligible_i(eligible),
    .prio_i    (prio_q),
    .valid_o   (sel_valid),
    .id_o      (sel_id),
    .prio_o    (sel_prio)
  );

  assign vec_off = 32'(sel_id) << VEC_STRIDE_LOG2;
  assign sel_vec = VEC_BASE + ADDR_W'(vec_off);

  // Current level: highest in-service bit; bit 0 is never set, so 0 means idle.
  always_comb begin
    cur_level = '0;
    for (int l = 1; l < NUM_LEVELS; l++) begin
      if (in_service_q[l]) cur_level = PRIO_W'(l);
    end
  end

  assign ack_fire = int_ack && (state_q == REQ);
  assign ret_fire = int_return && (|in_service_q);
  assign w1c_pend = cfg_wen && (cfg_addr == ADDR_PENDING);

  // Return clears first so an ack in the same cycle can set a bit it just freed.
  always_comb begin
    in_service_d = in_service_q;
    last_id_d    = last_id_q;
    if (ret_fire) in_service_d[cur_level] = 1'b0;
    if (ack_fire) begin
      in_service_d[req_prio_q] = 1'b1;
      last_id_d                = int_id_q;
    end
  end

  // Clears are applied before the set so a fresh edge in the same cycle survives.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (ack_fire && (int_id_q == 5'(i))) pend_d[i] = 1'b0;
      if (w1c_pend && cfg_wdata[i])        pend_d[i] = 1'b0;
      if (edge_q[i] && edge_rise[i])       pend_d[i] = 1'b1;
    end
  end

  always_comb begin
    logic [3:0] nib;
    ctrl_en_d = ctrl_en_q;
    mask_d    = mask_q;
    edge_d    = edge_q;
    prio_d    = prio_q;
    nib       = 4'd0;
    if (cfg_wen) begin
      if (cfg_addr == ADDR_CTRL) ctrl_en_d = cfg_wdata[0];
      if (cfg_addr == ADDR_MASK) mask_d    = cfg_wdata[NUM_IRQ-1:0];
      if (cfg_addr == ADDR_EDGE) edge_d    = cfg_wdata[NUM_IRQ-1:0];
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (cfg_addr == ADDR_PRIO_BASE + 4'(i / PRIO_PER_REG)) begin
          nib       = prio_nibble_extract(cfg_wdata, 3'(i % PRIO_PER_REG));
          prio_d[i] = nib[PRIO_W-1:0];
        end
      end
    end
  end

  // Read mux reflects register state before any write in the same cycle.
  always_comb begin
    cfg_rdata_d = 32'd0;
    case (cfg_addr)
      ADDR_CTRL:       cfg_rdata_d = {31'd0, ctrl_en_q};
      ADDR_MASK:       cfg_rdata_d = 32'(mask_q);
      ADDR_EDGE:       cfg_rdata_d = 32'(edge_q);
      ADDR_PENDING:    cfg_rdata_d = 32'(eff_pend);
      ADDR_IN_SERVICE: cfg_rdata_d = 32'(in_service_q);
      ADDR_LAST_ID:    cfg_rdata_d = 32'(last_id_q);
      default: begin
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (cfg_addr == ADDR_PRIO_BASE + 4'(i / PRIO_PER_REG)) begin
            cfg_rdata_d = prio_nibble_insert(cfg_rdata_d, 3'(i % PRIO_PER_REG), 4'(prio_q[i]));
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_en_q    <= 1'b0;
      mask_q       <= '0;
      edge_q       <= '0;
      prio_q       <= '0;
      irq_prev_q   <= '0;
      pend_q       <= '0;
      in_service_q <= '0;
      last_id_q    <= 5'd0;
      cfg_rdata_q  <= 32'd0;
    end else begin
      ctrl_en_q    <= ctrl_en_d;
      mask_q       <= mask_d;
      edge_q       <= edge_d;
      prio_q       <= prio_d;
      irq_prev_q   <= irq_in;
      pend_q       <= pend_d;
      in_service_q <= in_service_d;
      last_id_q    <= last_id_d;
      cfg_rdata_q  <= cfg_rdata_d;
    end
  end

  // Request FSM: id, vector and priority are frozen on entry to REQ and held
  // until the hazard unit acknowledges, regardless of mask or source changes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      interrupt_q <= 1'b0;
      int_id_q    <= 5'd0;
      int_vec_q   <= '0;
      req_prio_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid && (sel_prio > cur_level)) begin
            state_q     <= REQ;
            interrupt_q <= 1'b1;
            int_id_q    <= sel_id;
            int_vec_q   <= sel_vec;
            req_prio_q  <= sel_prio;
          end
        end
        REQ: begin
          if (int_ack) begin
            state_q     <= IDLE;
            interrupt_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          interrupt_q <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt    = interrupt_q;
  assign int_id       = int_id_q;
  assign int_vec_addr = int_vec_q;
  assign cfg_rdata    = cfg_rdata_q;

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// tb/tb_vectored_interrupt_controller.sv - directed self-checking bench for vectored_interrupt_controller
module tb_vectored_interrupt_controller;

  logic        clock;
  logic        reset;
  logic [7:0]  irq_in;
  logic        interrupt;
  logic [13:0] int_vec_addr;
  logic [4:0]  int_id;
  logic        int_ack;
  logic        int_return;
  logic        cfg_wen;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  int total;
  int bad;

  vectored_interrupt_controller dut (
    .clock       (clock),
    .reset       (reset),
    .irq_in      (irq_in),
    .interrupt   (interrupt),
    .int_vec_addr(int_vec_addr),
    .int_id      (int_id),
    .int_ack     (int_ack),
    .int_return  (int_return),
    .cfg_wen     (cfg_wen),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cfg_wen   = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    cyc();
    cfg_wen   = 1'b0;
    cfg_wdata = 32'd0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    cfg_addr = a;
    cyc();
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic pulse(input logic [7:0] m);
    irq_in = m;
    cyc();
    irq_in = 8'd0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
  endtask

  task automatic ret();
    int_return = 1'b1;
    cyc();
    int_return = 1'b0;
  endtask

  task automatic chk_req(input string tag, input logic [4:0] id, input logic [13:0] vec);
    chk({tag, "_irq"}, 32'(interrupt), 32'd1);
    chk({tag, "_id"},  32'(int_id), 32'(id));
    chk({tag, "_vec"}, 32'(int_vec_addr), 32'(vec));
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    irq_in     = 8'd0;
    int_ack    = 1'b0;
    int_return = 1'b0;
    cfg_wen    = 1'b0;
    cfg_addr   = 4'd0;
    cfg_wdata  = 32'd0;
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state
    chk("rst_irq", 32'(interrupt), 32'd0);
    chk("rst_id", 32'(int_id), 32'd0);
    chk("rst_vec", 32'(int_vec_addr), 32'd0);
    chk("rst_rdata", cfg_rdata, 32'd0);
    rd(4'd0, 32'd0, "rst_ctrl");
    rd(4'd1, 32'd0, "rst_mask");

    // Single edge channel 3, prio 1
    wr(4'd0, 32'd1);
    wr(4'd1, 32'hFF);
    wr(4'd2, 32'hFF);
    wr(4'd8, 32'h0000_1000);
    rd(4'd8, 32'h0000_1000, "prio_rb");
    rd(4'd0, 32'd1, "ctrl_rb");
    pulse(8'h08);
    chk("e3_t1", 32'(interrupt), 32'd0);
    cyc();
    chk_req("e3", 5'd3, 14'h001C);
    ack();
    chk("e3_ackdrop", 32'(interrupt), 32'd0);
    rd(4'd4, 32'h2, "e3_insvc");
    rd(4'd5, 32'd3, "e3_lastid");
    chk("e3_noreq", 32'(interrupt), 32'd0);
    ret();
    rd(4'd4, 32'h0, "e3_ret");

    // Tie between channels 2 and 5 at prio 2
    wr(4'd8, 32'h0020_0200);
    pulse(8'h24);
    cyc();
    chk_req("tie1", 5'd2, 14'h0018);
    ack();
    cyc();
    cyc();
    chk("tie_blocked", 32'(interrupt), 32'd0);
    ret();
    chk("tie_ret0", 32'(interrupt), 32'd0);
    cyc();
    chk_req("tie2", 5'd5, 14'h0024);
    ack();
    ret();

    // Preemption: ch1 prio1, ch4 prio3, ch6 prio1
    wr(4'd8, 32'h0103_0010);
    pulse(8'h02);
    cyc();
    chk_req("pre1", 5'd1, 14'h0014);
    ack();
    pulse(8'h10);
    cyc();
    chk_req("pre4", 5'd4, 14'h0020);
    ack();
    rd(4'd4, 32'hA, "pre_insvc");
    pulse(8'h40);
    cyc();
    chk("pre6_blk_a", 32'(interrupt), 32'd0);
    ret();
    cyc();
    chk("pre6_blk_b", 32'(interrupt), 32'd0);
    ret();
    chk("pre6_blk_c", 32'(interrupt), 32'd0);
    cyc();
    chk_req("pre6", 5'd6, 14'h0028);
    ack();
    ret();
    rd(4'd4, 32'h0, "pre_clear");

    // Level channel 0 at prio 2
    wr(4'd2, 32'hFE);
    wr(4'd8, 32'h0000_0002);
    irq_in = 8'h01;
    cyc();
    chk_req("lvl1", 5'd0, 14'h0010);
    ack();
    chk("lvl_ackdrop", 32'(interrupt), 32'd0);
    rd(4'd3, 32'h01, "lvl_pend");
    chk("lvl_blk", 32'(interrupt), 32'd0);
    ret();
    chk("lvl_ret0", 32'(interrupt), 32'd0);
    cyc();
    chk_req("lvl2", 5'd0, 14'h0010);
    ack();
    irq_in = 8'h00;
    ret();
    cyc();
    cyc();
    chk("lvl_dropped", 32'(interrupt), 32'd0);
    rd(4'd4, 32'h0, "lvl_insvc");

    // Edge vs W1C race on channel 7 (prio 0 so it stays pending)
    wr(4'd2, 32'hFF);
    wr(4'd8, 32'h0);
    pulse(8'h80);
    rd(4'd3, 32'h80, "w1c_pend");
    irq_in    = 8'h80;
    cfg_wen   = 1'b1;
    cfg_addr  = 4'd3;
    cfg_wdata = 32'h80;
    cyc();
    cfg_wen   = 1'b0;
    irq_in    = 8'h00;
    rd(4'd3, 32'h80, "w1c_race");
    chk("w1c_noreq", 32'(interrupt), 32'd0);
    wr(4'd3, 32'h80);
    rd(4'd3, 32'h0, "w1c_clear");

    // Mask and disable while in REQ: request is held
    wr(4'd8, 32'h0000_1000);
    pulse(8'h08);
    cyc();
    chk_req("mreq", 5'd3, 14'h001C);
    wr(4'd1, 32'hF7);
    chk_req("mmask", 5'd3, 14'h001C);
    wr(4'd0, 32'd0);
    cyc();
    chk_req("mdis", 5'd3, 14'h001C);
    ack();
    chk("m_ackdrop", 32'(interrupt), 32'd0);
    ret();

    // Reset during REQ
    wr(4'd0, 32'd1);
    wr(4'd1, 32'hFF);
    pulse(8'h08);
    cyc();
    chk_req("rreq", 5'd3, 14'h001C);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rr_irq", 32'(interrupt), 32'd0);
    chk("rr_id", 32'(int_id), 32'd0);
    chk("rr_vec", 32'(int_vec_addr), 32'd0);
    chk("rr_rdata", cfg_rdata, 32'd0);
    rd(4'd0, 32'd0, "rr_ctrl");
    rd(4'd1, 32'd0, "rr_mask");
    rd(4'd8, 32'd0, "rr_prio");
    rd(4'd5, 32'd0, "rr_lastid");
    chk("rr_idle", 32'(interrupt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
